// File: rtl/spi_arb.sv
// spi_arb: shares one SPI master between the pot requester and the calibration EEPROM.
// Round-robin grant, one-shot launch, stall timeout and slave-select demux for the granted target.
module spi_arb #(
   parameter logic [11:0] TMO_CYC = 12'd4000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pot_req,
   input  logic [1:0]  pot_sel,
   input  logic [15:0] pot_cmd,
   input  logic        eep_req,
   input  logic [15:0] eep_cmd,
   output logic        pot_done,
   output logic        eep_done,
   output logic [15:0] eep_rdata,
   output logic        err,
   output logic        spi_wrt,
   output logic [15:0] spi_cmd,
   input  logic        spi_done,
   input  logic [15:0] spi_rdata,
   input  logic        spi_ss_n,
   output logic        ch1_ss_n,
   output logic        ch2_ss_n,
   output logic        ch3_ss_n,
   output logic        trig_ss_n,
   output logic        EEP_ss_n
);

   typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_t;

   state_t      state_q, state_d;
   logic        gnt_eep_q, gnt_eep_d;
   logic        last_eep_q, last_eep_d;
   logic [1:0]  sel_q, sel_d;
   logic [15:0] cmd_q, cmd_d;
   logic [15:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [11:0] tmo_q, tmo_d;
   logic        spi_wrt_q, spi_wrt_d;
   logic        pot_done_q, pot_done_d;
   logic        eep_done_q, eep_done_d;
   logic        xfer;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         gnt_eep_q  <= 1'b0;
         last_eep_q <= 1'b0;
         sel_q      <= 2'b00;
         cmd_q      <= 16'h0000;
         rdata_q    <= 16'h0000;
         err_q      <= 1'b0;
         tmo_q      <= 12'd0;
         spi_wrt_q  <= 1'b0;
         pot_done_q <= 1'b0;
         eep_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_eep_q  <= gnt_eep_d;
         last_eep_q <= last_eep_d;
         sel_q      <= sel_d;
         cmd_q      <= cmd_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         tmo_q      <= tmo_d;
         spi_wrt_q  <= spi_wrt_d;
         pot_done_q <= pot_done_d;
         eep_done_q <= eep_done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_eep_d  = gnt_eep_q;
      last_eep_d = last_eep_q;
      sel_d      = sel_q;
      cmd_d      = cmd_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      tmo_d      = tmo_q;
      spi_wrt_d  = 1'b0;
      pot_done_d = 1'b0;
      eep_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            // EEPROM wins a tie unless it was the one served last
            if (pot_req || eep_req) begin
               gnt_eep_d = eep_req && (!pot_req || !last_eep_q);
               cmd_d     = gnt_eep_d ? eep_cmd : pot_cmd;
               sel_d     = pot_sel;
               state_d   = LAUNCH;
            end
         end
         LAUNCH: begin
            spi_wrt_d = 1'b1;
            tmo_d     = 12'd0;
            state_d   = BUSY;
         end
         BUSY: begin
            tmo_d = tmo_q + 12'd1;
            if (spi_done) begin
               if (gnt_eep_q) rdata_d = spi_rdata;
               state_d = DONE;
            end else if (tmo_d == TMO_CYC) begin
               err_d   = 1'b1;
               state_d = DONE;
            end
            if (state_d == DONE) begin
               pot_done_d = !gnt_eep_q;
               eep_done_d = gnt_eep_q;
            end
         end
         DONE: begin
            last_eep_d = gnt_eep_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Only the granted target sees the master's select, and only while a transfer is live
   assign xfer      = (state_q == LAUNCH) || (state_q == BUSY);
   assign EEP_ss_n  = (xfer && gnt_eep_q) ? spi_ss_n : 1'b1;
   assign ch1_ss_n  = (xfer && !gnt_eep_q && sel_q == 2'b00) ? spi_ss_n : 1'b1;
   assign ch2_ss_n  = (xfer && !gnt_eep_q && sel_q == 2'b01) ? spi_ss_n : 1'b1;
   assign ch3_ss_n  = (xfer && !gnt_eep_q && sel_q == 2'b10) ? spi_ss_n : 1'b1;
   assign trig_ss_n = (xfer && !gnt_eep_q && sel_q == 2'b11) ? spi_ss_n : 1'b1;

   assign spi_wrt   = spi_wrt_q;
   assign spi_cmd   = cmd_q;
   assign pot_done  = pot_done_q;
   assign eep_done  = eep_done_q;
   assign eep_rdata = rdata_q;
   assign err       = err_q;

endmodule

// File: tb/tb_spi_arb.sv
// Bench for spi_arb: directed scenarios plus randomized transfers checked against
// a transaction-level model of grant order, data capture and the sticky error flag.
module tb_spi_arb;
   localparam logic [11:0] TMO = 12'd20;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pot_req, eep_req;
   logic [1:0]  pot_sel;
   logic [15:0] pot_cmd, eep_cmd;
   logic        pot_done, eep_done;
   logic [15:0] eep_rdata;
   logic        err;
   logic        spi_wrt;
   logic [15:0] spi_cmd;
   logic        spi_done;
   logic [15:0] spi_rdata;
   logic        spi_ss_n;
   logic        ch1_ss_n, ch2_ss_n, ch3_ss_n, trig_ss_n, EEP_ss_n;
   logic [4:0]  ss_vec;

   always #5 clk = ~clk;

   spi_arb #(.TMO_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .pot_req(pot_req), .pot_sel(pot_sel), .pot_cmd(pot_cmd),
      .eep_req(eep_req), .eep_cmd(eep_cmd),
      .pot_done(pot_done), .eep_done(eep_done), .eep_rdata(eep_rdata), .err(err),
      .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .spi_done(spi_done), .spi_rdata(spi_rdata),
      .spi_ss_n(spi_ss_n),
      .ch1_ss_n(ch1_ss_n), .ch2_ss_n(ch2_ss_n), .ch3_ss_n(ch3_ss_n),
      .trig_ss_n(trig_ss_n), .EEP_ss_n(EEP_ss_n)
   );

   assign ss_vec = {ch1_ss_n, ch2_ss_n, ch3_ss_n, trig_ss_n, EEP_ss_n};

   int          n_vec = 0;
   int          n_err = 0;
   bit          m_last_eep;
   logic [15:0] m_rdata;
   bit          m_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // expected {ch1,ch2,ch3,trig,eep} selects with spi_ss_n driven low
   function automatic logic [4:0] exp_ss(input bit eep, input logic [1:0] sel, input bit act);
      logic [4:0] v;
      v = 5'b11111;
      if (act) begin
         if (eep) v[0] = 1'b0;
         else     v[4 - int'(sel)] = 1'b0;
      end
      return v;
   endfunction

   task automatic do_txn(input bit rp, input bit re, input logic [1:0] psel,
                         input logic [15:0] pcmd, input logic [15:0] ecmd,
                         input bit tmo, input logic [15:0] rd, input int dly,
                         input bit drop, input bit stray);
      bit          w_eep;
      int          k;
      logic [15:0] exp_cmd;
      @(negedge clk);
      chk("idle_pot_done", pot_done, 1'b0);
      chk("idle_eep_done", eep_done, 1'b0);
      if (rp && !pot_req) begin pot_req = 1'b1; pot_sel = psel; pot_cmd = pcmd; end
      if (re && !eep_req) begin eep_req = 1'b1; eep_cmd = ecmd; end
      if (!pot_req && !eep_req) begin pot_req = 1'b1; pot_sel = psel; pot_cmd = pcmd; end
      if (stray) begin spi_done = 1'b1; spi_rdata = 16'($urandom); end
      w_eep   = eep_req && (!pot_req || !m_last_eep);
      exp_cmd = w_eep ? eep_cmd : pot_cmd;
      @(negedge clk);
      spi_done = 1'b0;
      spi_ss_n = 1'b0;
      chk("wrt_early", spi_wrt, 1'b0);
      @(negedge clk);
      chk("wrt", spi_wrt, 1'b1);
      chk("cmd", spi_cmd, exp_cmd);
      chk("ss_busy", ss_vec, exp_ss(w_eep, pot_sel, 1'b1));
      if (drop) begin
         if (w_eep) eep_req = 1'b0;
         else       pot_req = 1'b0;
      end
      if (tmo) begin
         for (k = 1; k <= int'(TMO) + 4; k++) begin
            @(negedge clk);
            if (pot_done || eep_done) break;
         end
         chk("tmo_latency", k, int'(TMO));
         m_err = 1'b1;
      end else begin
         repeat (dly) begin
            @(negedge clk);
            chk("early_done", {pot_done, eep_done}, 2'b00);
            chk("cmd_stable", spi_cmd, exp_cmd);
         end
         spi_done  = 1'b1;
         spi_rdata = rd;
         @(negedge clk);
         spi_done = 1'b0;
         if (w_eep) m_rdata = rd;
      end
      chk("pot_done", pot_done, !w_eep);
      chk("eep_done", eep_done, w_eep);
      chk("eep_rdata", eep_rdata, m_rdata);
      chk("err", err, m_err);
      chk("ss_done", ss_vec, 5'b11111);
      if (w_eep) eep_req = 1'b0;
      else       pot_req = 1'b0;
      spi_ss_n   = 1'b1;
      m_last_eep = w_eep;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; pot_req = 1'b0; eep_req = 1'b0; pot_sel = 2'b00;
      pot_cmd = 16'h0; eep_cmd = 16'h0; spi_done = 1'b0; spi_rdata = 16'h0; spi_ss_n = 1'b1;
      m_last_eep = 1'b0; m_rdata = 16'h0; m_err = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_wrt", spi_wrt, 1'b0);
      chk("rst_cmd", spi_cmd, 16'h0);
      chk("rst_done", {pot_done, eep_done}, 2'b00);
      chk("rst_rdata", eep_rdata, 16'h0);
      chk("rst_err", err, 1'b0);
      chk("rst_ss", ss_vec, 5'b11111);
      rst_n = 1'b1;

      // simultaneous after reset: EEPROM first, pending pot next
      do_txn(1, 1, 2'b01, 16'hA5A5, 16'h5A5A, 0, 16'h1111, 1, 0, 0);
      do_txn(0, 0, 2'b01, 16'h0000, 16'h0000, 0, 16'h2222, 2, 0, 0);
      // single pot to ch3, then EEPROM read at minimum latency, then pot leaves rdata alone
      do_txn(1, 0, 2'b10, 16'h13C0, 16'h0000, 0, 16'hBEEF, 3, 0, 0);
      do_txn(0, 1, 2'b00, 16'h0000, 16'h0300, 0, 16'h0034, 0, 0, 0);
      do_txn(1, 0, 2'b11, 16'h7777, 16'h0000, 0, 16'hCAFE, 1, 0, 0);
      // timeout, then a normal transfer with the flag still set
      do_txn(0, 1, 2'b00, 16'h0000, 16'h0301, 1, 16'h0000, 0, 0, 0);
      do_txn(1, 0, 2'b00, 16'h4444, 16'h0000, 0, 16'hD00D, 2, 0, 0);
      // sustained contention: grants must alternate
      for (int r = 0; r < 16; r++)
         do_txn(1, 1, 2'($urandom), 16'($urandom), 16'($urandom), 0, 16'($urandom),
                int'($urandom_range(0, 3)), 0, 0);
      for (int r = 0; r < 40; r++)
         do_txn(1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
                ($urandom_range(0, 7) == 0), 16'($urandom), int'($urandom_range(0, 5)),
                1'($urandom), 1'($urandom));

      // reset while BUSY
      @(negedge clk);
      pot_req = 1'b1; pot_sel = 2'b01; pot_cmd = 16'h9999;
      @(negedge clk);
      spi_ss_n = 1'b0;
      @(negedge clk);
      chk("rb_wrt", spi_wrt, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rb_ss", ss_vec, 5'b11111);
      chk("rb_done", {pot_done, eep_done}, 2'b00);
      chk("rb_wrt_low", spi_wrt, 1'b0);
      chk("rb_cmd", spi_cmd, 16'h0);
      chk("rb_err", err, 1'b0);
      chk("rb_rdata", eep_rdata, 16'h0);
      rst_n = 1'b1; pot_req = 1'b0; eep_req = 1'b0;
      @(negedge clk);
      spi_done = 1'b1; spi_rdata = 16'h5555;
      @(negedge clk);
      spi_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stray_done", {pot_done, eep_done}, 2'b00);
         chk("stray_ss", ss_vec, 5'b11111);
      end
      chk("stray_rdata", eep_rdata, 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
